// File: rtl/divisor_reloj_programable.sv
// Runtime-programmable clock divider: ~50% duty output of period 2*N plus a tick on each rising edge.
// Half-period N is loaded through a shadow register and adopted only at a half-period boundary.
module divisor_reloj_programable #(
    parameter int ANCHO       = 25,
    parameter int DIV_INICIAL = 32768
) (
    input  logic             relojNexys2,
    input  logic             reset,
    input  logic             habilitar,
    input  logic             cargar,
    input  logic [ANCHO-1:0] divisor,
    output logic             salidaReloj,
    output logic             tick,
    output logic             pendiente,
    output logic             error_div
);

    localparam logic [ANCHO-1:0] N_RESET = ANCHO'(DIV_INICIAL);

    logic [ANCHO-1:0] cnt;
    logic [ANCHO-1:0] n_act;
    logic [ANCHO-1:0] shadow;
    logic             frontera;
    logic             carga_valida;
    logic             carga_nula;

    assign frontera     = (cnt == n_act - 1'b1);
    assign carga_valida = cargar && (divisor != '0);
    assign carga_nula   = cargar && (divisor == '0);

    always_ff @(posedge relojNexys2 or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            n_act       <= N_RESET;
            shadow      <= N_RESET;
            salidaReloj <= 1'b0;
            tick        <= 1'b0;
            pendiente   <= 1'b0;
            error_div   <= 1'b0;
        end else begin
            error_div <= carga_nula;
            if (habilitar) begin
                if (frontera) begin
                    cnt         <= '0;
                    salidaReloj <= ~salidaReloj;
                    tick        <= ~salidaReloj;
                    if (pendiente) begin
                        n_act     <= shadow;
                        pendiente <= 1'b0;
                    end
                end else begin
                    cnt  <= cnt + 1'b1;
                    tick <= 1'b0;
                end
                // A value captured on a boundary cycle waits for the following boundary.
                if (carga_valida) begin
                    shadow    <= divisor;
                    pendiente <= 1'b1;
                end
            end else begin
                cnt         <= '0;
                salidaReloj <= 1'b0;
                tick        <= 1'b0;
                if (pendiente) begin
                    n_act     <= shadow;
                    pendiente <= 1'b0;
                end
                // While stopped there is no period in flight, so a load applies at once.
                if (carga_valida) begin
                    shadow <= divisor;
                    n_act  <= divisor;
                end
            end
        end
    end

endmodule

// File: doc/divisor_reloj_programable.md
Name: divisor_reloj_programable

Overview:
Runtime-programmable clock divider for the Nexys 2 50 MHz board clock. It generates a ~50% duty output clock plus a one-cycle tick strobe, with half-period set through a load handshake. It drives the stepper-motor sequencers and any other slow-rate logic. Unlike a fixed counter-bit tap, any integer frequency 50 MHz/(2·N) is reachable, and rate changes take effect glitch-free at a period boundary.

Parameters:
ANCHO, 25, width of counter, divisor input and active half-period register
DIV_INICIAL, 32768, half-period N after reset (762.94 Hz at 50 MHz); must be >= 1 and < 2^ANCHO

Ports:
relojNexys2  input  1  50 MHz system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
habilitar  input  1  1 = divider runs; 0 = divider stopped and output held low
cargar  input  1  one-cycle strobe; samples divisor
divisor  input  ANCHO  requested half-period N in clock cycles (valid 1..2^ANCHO-1)
salidaReloj  output  1  divided clock, period 2·N cycles, high N / low N
tick  output  1  one-cycle pulse coincident with first high cycle of salidaReloj
pendiente  output  1  a loaded value awaits the next period boundary
error_div  output  1  one-cycle pulse: cargar with divisor = 0 rejected

Behaviour:
- One clock domain; reset is asynchronous and active-high. The clock is named relojNexys2 and the reset is named reset.
- Reset values:
  - cnt = 0, N_act = DIV_INICIAL, shadow = DIV_INICIAL.
  - salidaReloj = 0, tick = 0, pendiente = 0, error_div = 0.
- Reset asserted mid-operation returns all state to these values immediately. Any pending load is discarded.
- All outputs are registered.
- Running (habilitar = 1), each edge:
  - If cnt == N_act-1: cnt <= 0; salidaReloj <= ~salidaReloj; tick <= 1 only when salidaReloj was 0.
  - Also at that boundary, if pendiente = 1: N_act <= shadow and pendiente <= 0.
  - Otherwise: cnt <= cnt+1 and tick <= 0.
- Latency after habilitar rises with cnt = 0: the first salidaReloj rising edge (and tick) appears N_act edges later.
- A new N_act applies to the half-period starting at the boundary where it is adopted. No runt or stretched half-period mixes old and new N.
- N = 1 gives salidaReloj = relojNexys2/2 with tick every 2 cycles.
- Load handshake, case by case:
  - cargar = 1 and divisor != 0, running: shadow <= divisor, pendiente <= 1.
  - cargar = 1 and divisor != 0, stopped (habilitar = 0): shadow <= divisor, N_act <= divisor, pendiente stays 0.
  - cargar = 1 and divisor == 0: no state change except error_div <= 1 for one cycle. An existing pending value stays pending.
  - Repeated cargar before a boundary: last valid value wins.
  - cargar in the same cycle as a boundary: the value captured that cycle is NOT applied at that boundary. Any previously pending value is applied; the new value becomes pending for the next boundary.
- Stopped (habilitar = 0), each edge:
  - cnt <= 0, salidaReloj <= 0, tick <= 0.
  - If pendiente = 1: N_act <= shadow, pendiente <= 0.
- Re-enabling restarts from cnt = 0, low phase.
- Counter arithmetic is ANCHO-bit unsigned. cnt never exceeds N_act-1, so no wrap occurs.
- Max N = 2^ANCHO-1 gives 50e6/(2·(2^25-1)) ≈ 0.745 Hz.

Test Plan:
1. Reset, habilitar = 1, DIV_INICIAL overridden to 4 -> salidaReloj low for edges 1-4, rises after edge 4; period 8 cycles; tick high exactly the cycle salidaReloj first reads 1; 3 full periods checked.
2. Running N = 4, cargar with divisor = 2 on cnt = 1 -> pendiente = 1 until the next boundary. Current half-period completes at 4 cycles; subsequent half-periods are 2 cycles. No half-period of any other length appears.
3. cargar divisor = 0 while running N = 3 -> error_div pulses one cycle; N stays 3; pendiente unchanged; waveform uninterrupted.
4. cargar divisor = 6 on the exact boundary cycle while divisor = 5 is already pending -> next half-period 5 cycles, following ones 6.
5. habilitar = 0 with N = 3, cargar divisor = 1, then habilitar = 1 -> salidaReloj held 0 while stopped; pendiente stays 0; after re-enable salidaReloj toggles every cycle (period 2); tick every 2 cycles.
6. Assert reset asynchronously mid-high phase with pendiente = 1 -> salidaReloj, tick, pendiente drop to 0 without waiting for a clock edge. After release, N = DIV_INICIAL and the first rise occurs after DIV_INICIAL edges.
